// File: rtl/fifo_drain_stream.sv
// fifo_drain_stream: pops words from a synchronous FIFO (deq/valid_out handshake,
// one-cycle read latency) and presents them on a valid/ready stream with packet
// framing. A 2-entry output buffer absorbs the read latency so the block streams
// one word per cycle and never drops a word under backpressure.
// Optional feature: define FIFO_DRAIN_STATS_EN to add word_count/pkt_count outputs.
module fifo_drain_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en_in,
    input  logic                  fifo_empty,
    input  logic [31:0]           fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_deq,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  err_out
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]           word_count,
    output logic [15:0]           pkt_count
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  pending_q;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;

    logic                  pop_s;
    logic                  capture_s;
    logic [DATA_WIDTH-1:0] cap_data_s;
    logic [2:0]            inflight_s;

    assign pop_s      = m_valid_q & m_ready;
    assign capture_s  = fifo_valid & pending_q;
    assign cap_data_s = fifo_data[DATA_WIDTH-1:0];

    // Slots that will be claimed after this cycle: buffered words plus the word
    // returning now, minus the word leaving now. A new read is issued only if
    // its returning word is guaranteed a free slot.
    assign inflight_s = {1'b0, state_q} + {2'b00, pending_q} - {2'b00, pop_s};

    // Read request is combinational so a pop can immediately make room for a new read.
    always_comb begin
        fifo_deq = rst_in & en_in & ~fifo_empty & (inflight_s < 3'd2);
    end

    // Next buffer contents, occupancy, framing counter and sticky error.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (capture_s) begin
                    head_d  = cap_data_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (capture_s && pop_s) begin
                    head_d  = cap_data_s;
                end else if (capture_s) begin
                    tail_d  = cap_data_s;
                    state_d = TWO;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                if (capture_s && pop_s) begin
                    head_d = tail_q;
                    tail_d = cap_data_s;
                end else if (pop_s) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A returning word without a request, or a request with no returning word.
        err_d = err_q | (fifo_valid ^ pending_q);

        if (pop_s) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        m_valid_d = (state_d != EMPTY);
        m_last_d  = (state_d != EMPTY) && (cnt_d == LAST_CNT);
    end

    // State, buffer and registered stream outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= EMPTY;
            head_q    <= {DATA_WIDTH{1'b0}};
            tail_q    <= {DATA_WIDTH{1'b0}};
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            pending_q <= fifo_deq;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_data  = head_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign err_out = err_q;

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] word_cnt_q;
    logic [15:0] pkt_cnt_q;

    // Transfer and packet statistics, wrapping modulo 2^16.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            word_cnt_q <= 16'd0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            if (pop_s) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (pop_s && m_last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign word_count = word_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain_stream.sv
// Testbench for fifo_drain_stream: a queue-based FIFO model feeds the DUT,
// each word read from the model is pushed to a scoreboard with its expected
// framing flag, and an independent monitor checks every stream transfer.
module tb_fifo_drain_stream;

    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          en_in = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [31:0]   fifo_data = 32'd0;
    logic          fifo_valid = 1'b0;
    logic          fifo_deq;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          err_out;
`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0]   word_count;
    logic [15:0]   pkt_count;
`endif

    fifo_drain_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .en_in      (en_in),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_deq   (fifo_deq),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .err_out    (err_out)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .word_count (word_count),
        .pkt_count  (pkt_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          issued = 0;
    int          xfers = 0;
    int          rise_cyc = -1;
    int          first_xfer_cyc = 0;
    int          last_xfer_cyc = 0;
    logic [31:0] fq[$];
    exp_t        sb[$];
    bit          deq_prev = 1'b0;
    bit          deq_seen = 1'b0;
    bit          inj_err = 1'b0;
    logic [31:0] ret_word = 32'd0;

    bit            stall_prev = 1'b0;
    bit            valid_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: FIFO model answers last cycle's read, new inputs are
    // applied at the falling edge, and a read request is honoured from the model.
    task automatic step(input bit rdy, input bit en, input bit rst);
        @(negedge clk_in);
        cyc++;
        fifo_valid = deq_prev | inj_err;
        fifo_data  = inj_err ? 32'hDEAD_BEEF : ret_word;
        inj_err    = 1'b0;
        rst_in     = rst;
        m_ready    = rdy;
        en_in      = en;
        fifo_empty = (fq.size() == 0);
        if (!rst) begin
            sb.delete();
            issued = 0;
            xfers  = 0;
        end
        #1;
        deq_prev = 1'b0;
        deq_seen = fifo_deq;
        if (fifo_deq === 1'b1 && fq.size() != 0) begin
            ret_word = fq.pop_front();
            sb.push_back('{d: ret_word[DW-1:0], l: ((issued % BL) == BL - 1)});
            issued++;
            deq_prev = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || sb.size() != 0 || deq_prev) && n < 300) begin
            step(1'b1, 1'b1, 1'b1);
            n++;
        end
        repeat (3) step(1'b1, 1'b1, 1'b1);
        chk("drain_scoreboard_empty", sb.size(), 0);
        chk("drain_fifo_model_empty", fq.size(), 0);
    endtask

    // Monitor: checks each transfer against the scoreboard, the hold rule under
    // stall, and that no more than two words are ever outstanding.
    always @(negedge clk_in) begin
        exp_t e;
        #2;
        if (rst_in !== 1'b1) begin
            stall_prev = 1'b0;
            valid_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && !valid_prev) rise_cyc = cyc;
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", m_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_data", m_data, e.d);
                    chk("xfer_last", m_last, e.l);
                end
                xfers++;
                if (xfers == 1) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            chk("outstanding_le_2", ((issued - xfers) <= 2), 1);
            stall_prev = m_valid && !m_ready;
            valid_prev = m_valid;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        int dc;

        // Reset held with a non-empty FIFO.
        for (int i = 1; i <= 16; i++) fq.push_back(32'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("reset_deq", deq_seen, 0);
            chk("reset_valid", m_valid, 0);
            chk("reset_err", err_out, 0);
        end
        chk("reset_data", m_data, 0);
        chk("reset_last", m_last, 0);

        // Streaming 16 words with m_ready held high.
        step(1'b1, 1'b1, 1'b1);
        chk("first_deq_after_reset", deq_seen, 1);
        dc = cyc;
        drain();
        chk("stream_latency", rise_cyc - dc, 2);
        chk("stream_xfers", xfers, 16);
        chk("stream_back_to_back", last_xfer_cyc - first_xfer_cyc, 15);
        chk("stream_valid_falls", m_valid, 0);

        // Empty then refill with a single word.
        repeat (3) step(1'b1, 1'b1, 1'b1);
        fq.push_back(32'h0000_ABCD);
        step(1'b1, 1'b1, 1'b1);
        chk("refill_deq", deq_seen, 1);
        dc = cyc;
        drain();
        chk("refill_latency", rise_cyc - dc, 2);
        chk("refill_xfers", xfers, 17);

        // Backpressure mid-stream.
        for (int i = 0; i < 30; i++) fq.push_back(32'h100 + 32'(i));
        repeat (6) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i >= 1) chk("bp_no_deq", deq_seen, 0);
        end
        drain();

        // Randomised traffic, backpressure and enable.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'b1);
            if (!en_in) chk("en_low_no_deq", deq_seen, 0);
        end
        drain();
        chk("err_clean_run", err_out, 0);

`ifdef FIFO_DRAIN_STATS_EN
        // Statistics after 24 transfers.
        repeat (2) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) fq.push_back($urandom);
        drain();
        chk("stats_word_count", word_count, 24);
        chk("stats_pkt_count", pkt_count, 3);
`endif

        // Protocol error: a returning word nobody asked for.
        inj_err = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("err_rises", err_out, 1);
        chk("err_no_word_added", m_valid, 0);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        chk("err_sticky", err_out, 1);
        chk("err_no_word_later", m_valid, 0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        chk("err_cleared_by_reset", err_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
